// File: rtl/irrigation_zone_controller_if.sv
// Signal bundle between the raw field sensors / operator panel and the
// irrigation zone controller. The controller uses the slave view. The
// field side, or a bench that stands in for it, uses the master view.
interface irrigation_zone_controller_if #(
  parameter int ZONES = 4
);
  localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;

  // Raw tank level sensors, climate sensors and operator acknowledge
  logic             highLevel;
  logic             mediumLevel;
  logic             lowLevel;
  logic             temperatura;
  logic             umidadeAr;
  logic [ZONES-1:0] umidadeSolo;
  logic             alarmeAck;

  // Valve drivers and status
  logic             alarme;
  logic             erroSensor;
  logic             valvulaEntrada;
  logic [ZONES-1:0] gotejamento;
  logic [ZONES-1:0] aspersao;
  logic [ZW-1:0]    zonaAtiva;
  logic             ocupado;

  modport master (
    output highLevel, mediumLevel, lowLevel, temperatura, umidadeAr,
           umidadeSolo, alarmeAck,
    input  alarme, erroSensor, valvulaEntrada, gotejamento, aspersao,
           zonaAtiva, ocupado
  );

  modport slave (
    input  highLevel, mediumLevel, lowLevel, temperatura, umidadeAr,
           umidadeSolo, alarmeAck,
    output alarme, erroSensor, valvulaEntrada, gotejamento, aspersao,
           zonaAtiva, ocupado
  );
endinterface

// File: rtl/irrigation_zone_controller.sv
// Multi-zone irrigation controller. It debounces the tank level sensors
// and latches the tank alarm until an operator acknowledge arrives while
// the levels are sane. It runs the tank inlet valve with hysteresis and
// waters one soil zone at a time in round-robin order. Each zone gets a
// timed drip or spray interval followed by a mandatory rest.
module irrigation_zone_controller #(
  parameter int ZONES      = 4,
  parameter int DEBOUNCE   = 4,
  parameter int DRIP_TIME  = 16,
  parameter int SPRAY_TIME = 8,
  parameter int REST_TIME  = 8,
  parameter int CNT_W      = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  irrigation_zone_controller_if.slave bus
);

  localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WATER = 2'd1,
    REST  = 2'd2
  } state_t;

  // Level vectors are packed as {high, medium, low}
  logic [2:0]    rawLevel;
  logic [2:0]    level_q;
  logic [2:0]    level_d;
  logic [DW-1:0] dbCnt_q [3];
  logic [DW-1:0] dbCnt_d [3];

  logic levH;
  logic levM;
  logic levL;
  logic erro;
  logic cond;

  logic alarme_q;
  logic alarme_d;
  logic erroSensor_q;
  logic valvulaEntrada_q;
  logic valvulaEntrada_d;

  state_t           state_q;
  logic [CNT_W-1:0] timer_q;
  logic [ZW-1:0]    ptr_q;
  logic [ZW-1:0]    zonaAtiva_q;
  logic [ZONES-1:0] gotejamento_q;
  logic [ZONES-1:0] aspersao_q;
  logic             ocupado_q;

  logic          found;
  logic [ZW-1:0] pick;
  logic          sprayMode;
  logic          wetNow;
  logic [ZW-1:0] nextPtr;

  assign rawLevel = {bus.highLevel, bus.mediumLevel, bus.lowLevel};

  // Debounce next state: a level flips only after DEBOUNCE consecutive disagreeing samples
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 3; i++) begin
      dbCnt_d[i] = '0;
      if (rawLevel[i] != level_q[i]) begin
        if (dbCnt_q[i] == DW'(DEBOUNCE - 1)) begin
          level_d[i] = rawLevel[i];
        end else begin
          dbCnt_d[i] = dbCnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce registers; a full tank is assumed out of reset
  always_ff @(posedge clock) begin
    if (reset) begin
      level_q <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        dbCnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int i = 0; i < 3; i++) begin
        dbCnt_q[i] <= dbCnt_d[i];
      end
    end
  end

  assign levH = level_q[2];
  assign levM = level_q[1];
  assign levL = level_q[0];
  assign erro = (levH & ~levM) | (levM & ~levL);
  assign cond = erro | ~levL;

  // Alarm latch and inlet valve hysteresis next state
  always_comb begin
    alarme_d = cond | (alarme_q & ~bus.alarmeAck);
    valvulaEntrada_d = valvulaEntrada_q;
    if (levH | erro) begin
      valvulaEntrada_d = 1'b0;
    end else if (~levM) begin
      valvulaEntrada_d = 1'b1;
    end
  end

  // Tank supervision registers
  always_ff @(posedge clock) begin
    if (reset) begin
      alarme_q         <= 1'b0;
      erroSensor_q     <= 1'b0;
      valvulaEntrada_q <= 1'b0;
    end else begin
      alarme_q         <= alarme_d;
      erroSensor_q     <= erro;
      valvulaEntrada_q <= valvulaEntrada_d;
    end
  end

  // Round-robin search from ptr for the first dry zone; scanning backwards lets the nearest one win
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = ptr_q;
    idx   = 0;
    for (int i = ZONES - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= ZONES) begin
        idx = idx - ZONES;
      end
      if (!bus.umidadeSolo[idx]) begin
        found = 1'b1;
        pick  = ZW'(idx);
      end
    end
  end

  assign sprayMode = ~bus.umidadeAr | (~bus.temperatura & levM);
  assign wetNow    = bus.umidadeSolo[zonaAtiva_q];
  assign nextPtr   = (zonaAtiva_q == ZW'(ZONES - 1)) ? '0 : zonaAtiva_q + 1'b1;

  // Watering sequencer: IDLE picks a zone, WATER runs the timed valve, REST enforces the pause
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      ptr_q         <= '0;
      zonaAtiva_q   <= '0;
      gotejamento_q <= '0;
      aspersao_q    <= '0;
      ocupado_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!alarme_q && found) begin
            state_q     <= WATER;
            zonaAtiva_q <= pick;
            ocupado_q   <= 1'b1;
            if (sprayMode) begin
              timer_q    <= CNT_W'(SPRAY_TIME);
              aspersao_q <= ZONES'(1) << pick;
            end else begin
              timer_q       <= CNT_W'(DRIP_TIME);
              gotejamento_q <= ZONES'(1) << pick;
            end
          end
        end
        WATER: begin
          if ((timer_q == CNT_W'(1)) || wetNow || alarme_q) begin
            state_q       <= REST;
            timer_q       <= CNT_W'(REST_TIME);
            gotejamento_q <= '0;
            aspersao_q    <= '0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        REST: begin
          if (timer_q == CNT_W'(1)) begin
            state_q   <= IDLE;
            ptr_q     <= nextPtr;
            ocupado_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          state_q       <= IDLE;
          gotejamento_q <= '0;
          aspersao_q    <= '0;
          ocupado_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alarme         = alarme_q;
  assign bus.erroSensor     = erroSensor_q;
  assign bus.valvulaEntrada = valvulaEntrada_q;
  assign bus.gotejamento    = gotejamento_q;
  assign bus.aspersao       = aspersao_q;
  assign bus.zonaAtiva      = zonaAtiva_q;
  assign bus.ocupado        = ocupado_q;

endmodule

// File: tb/tb_irrigation_zone_controller.sv
// Directed bench for the irrigation zone controller. Inputs are driven and
// outputs sampled 1 ns after each rising edge, so every sample shows the
// registers as updated by the edge just passed.
module tb_irrigation_zone_controller;

  localparam int ZONES = 4;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  irrigation_zone_controller_if #(.ZONES(ZONES)) bus ();

  irrigation_zone_controller #(
    .ZONES(ZONES), .DEBOUNCE(4), .DRIP_TIME(16), .SPRAY_TIME(8),
    .REST_TIME(8), .CNT_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  // Free-running 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic setLevels(input logic h, input logic m, input logic l);
    bus.highLevel   = h;
    bus.mediumLevel = m;
    bus.lowLevel    = l;
  endtask

  task automatic pulseAck();
    bus.alarmeAck = 1'b1;
    tick(1);
    bus.alarmeAck = 1'b0;
  endtask

  // Reset with all sensors low, then watch the low level debounce into an alarm
  task automatic test_reset();
    reset = 1'b1;
    setLevels(1'b0, 1'b0, 1'b0);
    bus.temperatura = 1'b0;
    bus.umidadeAr   = 1'b0;
    bus.umidadeSolo = 4'b0000;
    bus.alarmeAck   = 1'b0;
    tick(2);
    checks++; if (bus.alarme !== 1'b0) begin errors++; $display("[TB] FAIL reset_alarme: got %b expected 0", bus.alarme); end
    checks++; if (bus.erroSensor !== 1'b0) begin errors++; $display("[TB] FAIL reset_erroSensor: got %b expected 0", bus.erroSensor); end
    checks++; if (bus.valvulaEntrada !== 1'b0) begin errors++; $display("[TB] FAIL reset_valve: got %b expected 0", bus.valvulaEntrada); end
    checks++; if (bus.gotejamento !== 4'b0000) begin errors++; $display("[TB] FAIL reset_drip: got %b expected 0000", bus.gotejamento); end
    checks++; if (bus.aspersao !== 4'b0000) begin errors++; $display("[TB] FAIL reset_spray: got %b expected 0000", bus.aspersao); end
    checks++; if (bus.zonaAtiva !== 2'd0) begin errors++; $display("[TB] FAIL reset_zona: got %0d expected 0", bus.zonaAtiva); end
    checks++; if (bus.ocupado !== 1'b0) begin errors++; $display("[TB] FAIL reset_ocupado: got %b expected 0", bus.ocupado); end
    reset = 1'b0;
    bus.umidadeSolo = 4'b1111;
    tick(4);
    checks++; if (bus.alarme !== 1'b0) begin errors++; $display("[TB] FAIL reset_alarm_cycle4: got %b expected 0", bus.alarme); end
    tick(1);
    checks++; if (bus.alarme !== 1'b1) begin errors++; $display("[TB] FAIL reset_alarm_cycle5: got %b expected 1", bus.alarme); end
    checks++; if (bus.valvulaEntrada !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty_valve: got %b expected 1", bus.valvulaEntrada); end
  endtask

  // Fill the tank, then check that a 3-cycle low-level glitch is ignored but 4 cycles is not
  task automatic test_glitch();
    setLevels(1'b1, 1'b1, 1'b1);
    bus.alarmeAck = 1'b1;
    tick(6);
    bus.alarmeAck = 1'b0;
    checks++; if (bus.alarme !== 1'b0) begin errors++; $display("[TB] FAIL glitch_full_alarme: got %b expected 0", bus.alarme); end
    checks++; if (bus.valvulaEntrada !== 1'b0) begin errors++; $display("[TB] FAIL glitch_full_valve: got %b expected 0", bus.valvulaEntrada); end
    bus.lowLevel = 1'b0;
    tick(3);
    bus.lowLevel = 1'b1;
    tick(3);
    checks++; if (bus.alarme !== 1'b0) begin errors++; $display("[TB] FAIL glitch_reject: got %b expected 0", bus.alarme); end
    bus.lowLevel = 1'b0;
    tick(4);
    checks++; if (bus.alarme !== 1'b0) begin errors++; $display("[TB] FAIL glitch_accept_early: got %b expected 0", bus.alarme); end
    tick(1);
    checks++; if (bus.alarme !== 1'b1) begin errors++; $display("[TB] FAIL glitch_accept: got %b expected 1", bus.alarme); end
    checks++; if (bus.erroSensor !== 1'b1) begin errors++; $display("[TB] FAIL glitch_erro: got %b expected 1", bus.erroSensor); end
  endtask

  // Acknowledge is ignored while the condition holds and honoured once levels are sane
  task automatic test_alarm_latch();
    pulseAck();
    checks++; if (bus.alarme !== 1'b1) begin errors++; $display("[TB] FAIL latch_ack_during_cond: got %b expected 1", bus.alarme); end
    bus.lowLevel = 1'b1;
    tick(6);
    checks++; if (bus.alarme !== 1'b1) begin errors++; $display("[TB] FAIL latch_hold_no_ack: got %b expected 1", bus.alarme); end
    checks++; if (bus.erroSensor !== 1'b0) begin errors++; $display("[TB] FAIL latch_erro_clear: got %b expected 0", bus.erroSensor); end
    pulseAck();
    checks++; if (bus.alarme !== 1'b0) begin errors++; $display("[TB] FAIL latch_ack_clear: got %b expected 0", bus.alarme); end
  endtask

  // Inlet valve opens below medium, holds between medium and high, closes at high or on error
  task automatic test_inlet();
    setLevels(1'b0, 1'b0, 1'b1);
    tick(5);
    checks++; if (bus.valvulaEntrada !== 1'b1) begin errors++; $display("[TB] FAIL inlet_open: got %b expected 1", bus.valvulaEntrada); end
    checks++; if (bus.alarme !== 1'b0) begin errors++; $display("[TB] FAIL inlet_no_alarm: got %b expected 0", bus.alarme); end
    bus.mediumLevel = 1'b1;
    tick(5);
    checks++; if (bus.valvulaEntrada !== 1'b1) begin errors++; $display("[TB] FAIL inlet_hold: got %b expected 1", bus.valvulaEntrada); end
    bus.highLevel = 1'b1;
    tick(5);
    checks++; if (bus.valvulaEntrada !== 1'b0) begin errors++; $display("[TB] FAIL inlet_close_high: got %b expected 0", bus.valvulaEntrada); end
    bus.mediumLevel = 1'b0;
    tick(5);
    checks++; if (bus.valvulaEntrada !== 1'b0) begin errors++; $display("[TB] FAIL inlet_error_valve: got %b expected 0", bus.valvulaEntrada); end
    checks++; if (bus.erroSensor !== 1'b1) begin errors++; $display("[TB] FAIL inlet_error_flag: got %b expected 1", bus.erroSensor); end
    checks++; if (bus.alarme !== 1'b1) begin errors++; $display("[TB] FAIL inlet_error_alarm: got %b expected 1", bus.alarme); end
    bus.mediumLevel = 1'b1;
    tick(5);
    pulseAck();
    checks++; if (bus.alarme !== 1'b0) begin errors++; $display("[TB] FAIL inlet_alarm_clear: got %b expected 0", bus.alarme); end
  endtask

  // Drip round robin over all four zones: 16 cycles on, then 8 rest plus 1 idle cycle off
  task automatic test_round_robin();
    logic [3:0] expDrip;
    int         badCycles;
    logic [3:0] badVal;
    bus.umidadeAr   = 1'b1;
    bus.temperatura = 1'b1;
    bus.umidadeSolo = 4'b0000;
    for (int z = 0; z < ZONES; z++) begin
      expDrip   = 4'b0001 << z;
      badCycles = 0;
      badVal    = 4'b0000;
      for (int c = 0; c < 16; c++) begin
        tick(1);
        if ((bus.gotejamento !== expDrip) || (bus.aspersao !== 4'b0000)) begin
          if (badCycles == 0) badVal = bus.gotejamento;
          badCycles++;
        end
      end
      checks++; if (badCycles != 0) begin errors++; $display("[TB] FAIL rr_drip_zone%0d: got %b on %0d cycles expected %b", z, badVal, badCycles, expDrip); end
      checks++; if (bus.zonaAtiva !== 2'(z)) begin errors++; $display("[TB] FAIL rr_zona_zone%0d: got %0d expected %0d", z, bus.zonaAtiva, z); end
      checks++; if (bus.ocupado !== 1'b1) begin errors++; $display("[TB] FAIL rr_ocupado_zone%0d: got %b expected 1", z, bus.ocupado); end
      badCycles = 0;
      badVal    = 4'b0000;
      for (int c = 0; c < 9; c++) begin
        tick(1);
        if ((bus.gotejamento !== 4'b0000) || (bus.ocupado !== (c < 8))) begin
          if (badCycles == 0) badVal = bus.gotejamento;
          badCycles++;
        end
      end
      checks++; if (badCycles != 0) begin errors++; $display("[TB] FAIL rr_rest_zone%0d: got %b on %0d cycles expected 0000 with ocupado for 8", z, badVal, badCycles); end
      if (z == ZONES - 1) bus.umidadeSolo = 4'b1111;
    end
    tick(3);
    checks++; if (bus.gotejamento !== 4'b0000) begin errors++; $display("[TB] FAIL rr_all_wet: got %b expected 0000", bus.gotejamento); end
  endtask

  // Spray on zone 2 aborted by wet soil, then zone 3 next, then an alarm abort and re-arm
  task automatic test_abort();
    int         badCycles;
    logic [3:0] badVal;
    bus.umidadeAr   = 1'b0;
    bus.umidadeSolo = 4'b0011;
    badCycles = 0;
    badVal    = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      if (bus.aspersao !== 4'b0100) begin
        if (badCycles == 0) badVal = bus.aspersao;
        badCycles++;
      end
    end
    checks++; if (badCycles != 0) begin errors++; $display("[TB] FAIL abort_spray_on: got %b on %0d cycles expected 0100", badVal, badCycles); end
    checks++; if (bus.zonaAtiva !== 2'd2) begin errors++; $display("[TB] FAIL abort_zona2: got %0d expected 2", bus.zonaAtiva); end
    bus.umidadeSolo = 4'b0110;
    tick(1);
    checks++; if (bus.aspersao !== 4'b0000) begin errors++; $display("[TB] FAIL abort_wet_drop: got %b expected 0000", bus.aspersao); end
    checks++; if (bus.ocupado !== 1'b1) begin errors++; $display("[TB] FAIL abort_rest_busy: got %b expected 1", bus.ocupado); end
    tick(7);
    checks++; if (bus.ocupado !== 1'b1) begin errors++; $display("[TB] FAIL abort_rest_end: got %b expected 1", bus.ocupado); end
    tick(1);
    checks++; if (bus.ocupado !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: got %b expected 0", bus.ocupado); end
    tick(1);
    checks++; if (bus.aspersao !== 4'b1000) begin errors++; $display("[TB] FAIL abort_next_zone: got %b expected 1000", bus.aspersao); end
    checks++; if (bus.zonaAtiva !== 2'd3) begin errors++; $display("[TB] FAIL abort_zona3: got %0d expected 3", bus.zonaAtiva); end
    bus.lowLevel = 1'b0;
    tick(5);
    checks++; if ((bus.alarme !== 1'b1) || (bus.aspersao !== 4'b1000)) begin errors++; $display("[TB] FAIL alarm_abort_pre: got alarme=%b spray=%b expected alarme=1 spray=1000", bus.alarme, bus.aspersao); end
    tick(1);
    checks++; if (bus.aspersao !== 4'b0000) begin errors++; $display("[TB] FAIL alarm_abort_drop: got %b expected 0000", bus.aspersao); end
    bus.umidadeSolo = 4'b0000;
    tick(12);
    checks++; if ((bus.aspersao !== 4'b0000) || (bus.ocupado !== 1'b0)) begin errors++; $display("[TB] FAIL alarm_blocks_idle: got spray=%b ocupado=%b expected 0000 and 0", bus.aspersao, bus.ocupado); end
    bus.lowLevel = 1'b1;
    tick(5);
    pulseAck();
    checks++; if ((bus.alarme !== 1'b0) || (bus.aspersao !== 4'b0000)) begin errors++; $display("[TB] FAIL rearm_ack: got alarme=%b spray=%b expected 0 and 0000", bus.alarme, bus.aspersao); end
    tick(1);
    checks++; if (bus.aspersao !== 4'b0001) begin errors++; $display("[TB] FAIL rearm_zone0: got %b expected 0001", bus.aspersao); end
  endtask

  // Reset in the middle of a watering interval clears every output at the next edge
  task automatic test_mid_reset();
    tick(2);
    reset = 1'b1;
    tick(1);
    checks++; if (bus.aspersao !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_spray: got %b expected 0000", bus.aspersao); end
    checks++; if (bus.ocupado !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ocupado: got %b expected 0", bus.ocupado); end
    checks++; if (bus.zonaAtiva !== 2'd0) begin errors++; $display("[TB] FAIL midreset_zona: got %0d expected 0", bus.zonaAtiva); end
    bus.umidadeSolo = 4'b1011;
    reset = 1'b0;
    tick(1);
    checks++; if ((bus.aspersao !== 4'b0100) || (bus.zonaAtiva !== 2'd2)) begin errors++; $display("[TB] FAIL midreset_restart: got spray=%b zona=%0d expected 0100 and 2", bus.aspersao, bus.zonaAtiva); end
  endtask

  // Run every scenario in order and print the summary
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_glitch();
    test_alarm_latch();
    test_inlet();
    test_round_robin();
    test_abort();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irrigation_zone_controller.md
# irrigation_zone_controller

Sequential, multi-zone successor to the combinational irrigation logic. It debounces the tank-level sensors and latches the alarm until an operator acknowledges it. It drives the tank inlet valve with hysteresis and waters up to ZONES independent soil zones, one at a time, in round-robin order. Each zone is watered by drip or spray for a timed interval, followed by a mandatory rest. It sits between the raw field sensors and the valve/pump drivers.

## Interface
- ZONES, 4: number of irrigation zones (≥2).
- DEBOUNCE, 4: consecutive stable samples required before a level sensor change is accepted (≥1).
- DRIP_TIME, 16: drip watering duration, cycles.
- SPRAY_TIME, 8: spray watering duration, cycles.
- REST_TIME, 8: mandatory idle cycles after each watering.
- CNT_W, 8: timer width; DRIP_TIME, SPRAY_TIME, REST_TIME ≤ 2^CNT_W−1.

- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high.
- highLevel, mediumLevel, lowLevel  in  1 each  raw tank level sensors (1 = water at that level).
- temperatura  in  1  1 = hot.
- umidadeAr  in  1  1 = humid air.
- umidadeSolo  in  ZONES  per-zone soil sensor (1 = wet).
- alarmeAck  in  1  operator acknowledge; one-cycle pulse or level.
- alarme  out  1  latched alarm.
- erroSensor  out  1  live inconsistent-level flag, registered.
- valvulaEntrada  out  1  tank inlet valve.
- gotejamento  out  ZONES  drip valve per zone, one-hot or zero.
- aspersao  out  ZONES  spray valve per zone, one-hot or zero.
- zonaAtiva  out  $clog2(ZONES)  index of the zone being watered or resting.
- ocupado  out  1  1 in WATER or REST.

## Operation
- Debounce: one counter per level sensor. The debounced value H/M/L takes the raw value after DEBOUNCE consecutive cycles in which raw ≠ debounced. Any agreeing sample resets the counter. Reset value H=M=L=1.
- erro = (H & !M) | (M & !L). cond = erro | !L.
- alarme: set when cond=1. Cleared only on alarmeAck=1 while cond=0. If cond=1 and ack arrive in the same cycle, alarme stays 1.
- valvulaEntrada: set when !M & !erro. Cleared when H | erro. Otherwise it holds its value, giving hysteresis between medium and high.
- Mode, evaluated at WATER entry and latched for the interval: spray if !umidadeAr | (!temperatura & M); drip otherwise.
- FSM states IDLE, WATER, REST. ptr is the round-robin pointer, reset 0.
  - IDLE: if alarme=0, search zones ptr, ptr+1, … (mod ZONES) for the first with umidadeSolo=0. If one is found, go to WATER with zonaAtiva = that zone and timer = DRIP_TIME or SPRAY_TIME. If none is found, stay in IDLE.
  - WATER: assert the mode's bit zonaAtiva and decrement the timer. Go to REST with timer=REST_TIME when any of these holds: the timer reaches 1, umidadeSolo[zonaAtiva]=1, or alarme=1.
  - REST: all valves off; decrement the timer. At 1, set ptr = zonaAtiva+1 (wrap to 0 after ZONES−1) and go to IDLE.
- An alarm abort still passes through REST. IDLE re-arms only once alarme=0.

## Timing
- All outputs are registered. Reset values: alarme=0, erroSensor=0, valvulaEntrada=0, gotejamento=0, aspersao=0, zonaAtiva=0, ocupado=0, state IDLE.
- Raw level change → debounced value change: DEBOUNCE cycles. Debounced change → alarme/erroSensor/valvulaEntrada: +1 cycle.
- IDLE decision → valve bit high on the next edge. The bit stays high exactly DRIP_TIME or SPRAY_TIME cycles unless aborted.
- Abort: the valve bit drops on the edge after the soil-wet or alarm condition is sampled.
- REST lasts exactly REST_TIME cycles. The earliest next valve assertion is REST_TIME+1 cycles after the previous valve drop.
- Reset asserted mid-operation returns everything to reset values on the next edge; timers and ptr clear.

## Test plan
- Reset: hold reset 2 cycles with all sensors 0 → all outputs 0. After release, L goes to 0 after 4 cycles and alarme=1 at cycle 5.
- Glitch rejection: tank full; pulse lowLevel=0 for 3 cycles → alarme stays 0. Hold it 0 for 4 cycles → alarme=1 one cycle later.
- Alarm latch: set cond, then ack while cond=1 → alarme stays 1. Restore levels, then ack → alarme=0 on the next edge.
- Inlet hysteresis: levels 1/1/1 → 1/0/0 (medium drops) → valve 1. Levels rise to medium only → valve stays 1. High=1 → valve 0. Set H=1, M=0 (erro) → valve 0 and erroSensor=1.
- Round robin: umidadeSolo=4'b0000, umidadeAr=1, temperatura=1 → gotejamento cycles through 0001, 0010, 0100, 1000. Each is high for 16 cycles, with 8 rest cycles between.
- Abort: spray on zone 2 (umidadeAr=0). Raise umidadeSolo[2] after 3 cycles → aspersao drops next edge, REST for 8 cycles, next candidate is zone 3.
